sram_bus_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-port SRAM-like memory bus between the CPU's instruction-fetch port and data-access port. It sits between the pipeline's fetch stage (pcF/instrF side) and memory stage (address, write data, byte enables, read data side) and the external memory. It serialises requests, runs the address/data handshake, latches results and drives per-port stall outputs back into the pipeline hazard logic.

---
 rtl/sram_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one single-port memory bus between the fetch and data ports
// Ports: clk, rst (async, active-low);
//   fetch side inst_req/inst_addr/inst_cancel in, inst_rdata/inst_done/inst_stall out;
//   data side data_req/data_wen/data_addr/data_wdata in, data_rdata/data_done/data_stall out;
//   bus side mem_req/mem_wr/mem_wen/mem_addr/mem_wdata out, mem_addr_ok/mem_data_ok/mem_rdata in.
module sram_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_cancel,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_done,
  output logic              inst_stall,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  output logic              data_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} state_e;
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  state_e state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic discard_q, discard_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0] wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic inst_done_q, inst_done_d;
  logic data_done_q, data_done_d;
  logic idle_free, grant_d, grant_i, i_busy, keep;
  // The done cycle is never a grant slot: a request still high then is the one just served.
  assign idle_free = state_q == IDLE && !inst_done_q && !data_done_q;
  assign grant_d   = idle_free && data_req && (!inst_req || starve_q < SMAX);
  assign grant_i   = idle_free && inst_req && !grant_d;
  assign i_busy    = state_q == I_ADDR || state_q == I_DATA;
  assign keep      = !(discard_q || inst_cancel);
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = D_ADDR;
          addr_d  = data_addr;
          wen_d   = data_wen;
          wdata_d = data_wdata;
        end else if (grant_i) begin
          state_d = I_ADDR;
          addr_d  = inst_addr;
          wen_d   = '0;
        end
      end
      I_ADDR: state_d = mem_addr_ok ? I_DATA : I_ADDR;
      D_ADDR: state_d = mem_addr_ok ? D_DATA : D_ADDR;
      I_DATA: begin
        if (mem_data_ok) begin
          state_d      = IDLE;
          inst_done_d  = keep;
          inst_rdata_d = keep ? mem_rdata : inst_rdata_q;
        end
      end
      D_DATA: begin
        if (mem_data_ok) begin
          state_d      = IDLE;
          data_done_d  = 1'b1;
          data_rdata_d = wen_q == '0 ? mem_rdata : data_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Cancelled fetches still finish on the bus; the flag only suppresses the result.
    discard_d = state_d != IDLE && (discard_q || (i_busy && inst_cancel));
    starve_d  = (grant_i || !inst_req) ? '0 :
                (grant_d && starve_q != SMAX) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      discard_q    <= 1'b0;
      addr_q       <= '0;
      wen_q        <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      discard_q    <= discard_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
    end
  end
  assign mem_req    = state_q == I_ADDR || state_q == D_ADDR;
  assign mem_wr     = |wen_q;
  assign mem_wen    = wen_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign inst_done  = inst_done_q;
  assign inst_stall = inst_req & ~inst_done_q;
  assign data_rdata = data_rdata_q;
  assign data_done  = data_done_q;
  assign data_stall = data_req & ~data_done_q;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: scoreboard bench for sram_bus_arbiter
module tb_sram_bus_arbiter;
  logic clk, rst;
  logic inst_req, inst_cancel, inst_done, inst_stall;
  logic [31:0] inst_addr, inst_rdata;
  logic data_req, data_done, data_stall;
  logic [3:0] data_wen;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0] mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int vectors = 0;
  int miscompares = 0;
  int dw = 0;
  logic late_ok = 1'b0;

  typedef struct {logic [31:0] addr; logic wr; logic [3:0] wen; logic [31:0] wdata;} bus_t;
  typedef struct {logic port; logic [31:0] rdata;} done_t;
  bus_t exp_bus[$];
  done_t exp_done[$];
  bus_t b;
  done_t d;

  sram_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_rdata(inst_rdata), .inst_done(inst_done), .inst_stall(inst_stall),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_done(data_done), .data_stall(data_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    case (a)
      32'hBFC00000: return 32'h24080001;
      32'hBFC00004: return 32'h3C1DA000;
      32'hBFC00008: return 32'h8FBF0010;
      32'hBFC00010: return 32'hDEAD0010;
      32'hBFC00014: return 32'h27BDFFE8;
      32'h80000020: return 32'h11112222;
      32'h80000030: return 32'h33334444;
      32'h80000040: return 32'h40404040;
      32'h80000044: return 32'h44444444;
      32'h80000048: return 32'h48484848;
      32'h8000004C: return 32'h4C4C4C4C;
      32'h80000050: return 32'h50505050;
      default:      return 32'hFFFFFFFF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got no event within bound, expected event", name);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic wr, input logic [3:0] wen, input logic [31:0] wd);
    exp_bus.push_back('{addr: a, wr: wr, wen: wen, wdata: wd});
  endtask

  task automatic push_done(input logic port, input logic [31:0] v);
    exp_done.push_back('{port: port, rdata: v});
  endtask

  // Memory responder: zero address wait, dw data waits.
  initial begin
    int ph, cnt;
    logic [31:0] cur;
    ph = 0; cnt = 0; cur = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      if (!rst) begin
        ph = 0; cnt = 0;
      end else if (ph == 0) begin
        if (late_ok) begin
          mem_data_ok = 1'b1;
          mem_rdata = 32'hBADBAD00;
        end else if (mem_req) begin
          mem_addr_ok = 1'b1;
          cur = mem_addr;
          ph = 1; cnt = 0;
        end
      end else if (cnt == dw) begin
        mem_data_ok = 1'b1;
        mem_rdata = rd(cur);
        ph = 0; cnt = 0;
      end else cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst && mem_req && mem_addr_ok) begin
      if (exp_bus.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL bus_unexpected: got addr %h expected none", mem_addr);
      end else begin
        b = exp_bus.pop_front();
        chk("bus_addr", mem_addr, b.addr);
        chk("bus_wr", 32'(mem_wr), 32'(b.wr));
        chk("bus_wen", 32'(mem_wen), 32'(b.wen));
        if (b.wr) chk("bus_wdata", mem_wdata, b.wdata);
      end
    end
  end

  always @(negedge clk) begin
    if (inst_done || data_done) begin
      if (exp_done.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL done_unexpected: got inst_done %b data_done %b expected none", inst_done, data_done);
      end else begin
        d = exp_done.pop_front();
        chk("done_port", 32'(data_done), 32'(d.port));
        chk("done_rdata", d.port ? data_rdata : inst_rdata, d.rdata);
      end
    end
  end

  task automatic wait_done(input logic port, output int n);
    bit seen = 0;
    n = 0;
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      n++;
      seen = port ? data_done : inst_done;
    end
    if (!seen) timeout(port ? "data_done_wait" : "inst_done_wait");
    else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_neg(input int which, input string name);
    bit seen = 0;
    int n = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = which == 0 ? (mem_req && mem_addr_ok) : which == 1 ? mem_data_ok : data_done;
    end
    if (!seen) timeout(name);
  endtask

  task automatic fetch(input logic [31:0] a);
    int n;
    inst_req = 1'b1; inst_addr = a;
    wait_done(1'b0, n);
    inst_req = 1'b0;
  endtask

  task automatic do_data(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd, output int n);
    data_req = 1'b1; data_addr = a; data_wen = wen; data_wdata = wd;
    wait_done(1'b1, n);
    data_req = 1'b0; data_wen = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    inst_req = 1'b0; inst_addr = '0; inst_cancel = 1'b0;
    data_req = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_wen", 32'(mem_wen), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk("rst_done", 32'({inst_done, data_done}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // single fetch, cycle by cycle
    push_bus(32'hBFC00000, 1'b0, 4'h0, 32'h0);
    push_done(1'b0, 32'h24080001);
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    @(negedge clk);
    chk("f_t0_stall", 32'(inst_stall), 1);
    chk("f_t0_mem_req", 32'(mem_req), 0);
    @(negedge clk);
    chk("f_t1_mem_req", 32'(mem_req), 1);
    chk("f_t1_stall", 32'(inst_stall), 1);
    @(negedge clk);
    chk("f_t2_mem_req", 32'(mem_req), 0);
    chk("f_t2_stall", 32'(inst_stall), 1);
    @(negedge clk);
    chk("f_t3_done", 32'(inst_done), 1);
    chk("f_t3_stall", 32'(inst_stall), 0);
    @(posedge clk); #1;
    inst_req = 1'b0;

    // load then store; store leaves data_rdata alone
    push_bus(32'h80000020, 1'b0, 4'h0, 32'h0);
    push_done(1'b1, 32'h11112222);
    push_bus(32'h80000010, 1'b1, 4'b0011, 32'hDEADBEEF);
    push_done(1'b1, 32'h11112222);
    do_data(32'h80000020, 4'h0, 32'h0, n);
    chk("load_latency", 32'(n), 3);
    do_data(32'h80000010, 4'b0011, 32'hDEADBEEF, n);
    chk("store_latency", 32'(n), 3);

    // simultaneous requests: data first
    push_bus(32'h80000030, 1'b0, 4'h0, 32'h0);
    push_bus(32'hBFC00004, 1'b0, 4'h0, 32'h0);
    push_done(1'b1, 32'h33334444);
    push_done(1'b0, 32'h3C1DA000);
    @(posedge clk); #1;
    fork
      fetch(32'hBFC00004);
      begin int m; do_data(32'h80000030, 4'h0, 32'h0, m); end
      begin wait_neg(2, "sim_data_done"); chk("sim_inst_stall", 32'(inst_stall), 1); end
    join

    // starvation limit: four data grants then the fetch
    for (int i = 0; i < 4; i++) push_bus(32'h80000040 + 32'(4 * i), 1'b0, 4'h0, 32'h0);
    push_bus(32'hBFC00008, 1'b0, 4'h0, 32'h0);
    push_bus(32'h80000050, 1'b0, 4'h0, 32'h0);
    push_done(1'b1, 32'h40404040);
    push_done(1'b1, 32'h44444444);
    push_done(1'b1, 32'h48484848);
    push_done(1'b1, 32'h4C4C4C4C);
    push_done(1'b0, 32'h8FBF0010);
    push_done(1'b1, 32'h50505050);
    @(posedge clk); #1;
    fork
      fetch(32'hBFC00008);
      begin
        int m;
        for (int i = 0; i < 5; i++) do_data(32'h80000040 + 32'(4 * i), 4'h0, 32'h0, m);
      end
    join

    // cancel in I_DATA with three data wait cycles
    dw = 3;
    push_bus(32'hBFC00010, 1'b0, 4'h0, 32'h0);
    push_bus(32'hBFC00014, 1'b0, 4'h0, 32'h0);
    push_done(1'b0, 32'h27BDFFE8);
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'hBFC00010;
    wait_neg(0, "cancel_addr_ok");
    @(posedge clk); #1;
    inst_cancel = 1'b1; inst_addr = 32'hBFC00014;
    @(posedge clk); #1;
    inst_cancel = 1'b0;
    wait_neg(1, "cancel_data_ok");
    @(negedge clk);
    chk("cancel_no_done", 32'(inst_done), 0);
    chk("cancel_rdata_kept", inst_rdata, 32'h8FBF0010);
    chk("cancel_stall", 32'(inst_stall), 1);
    dw = 0;
    wait_done(1'b0, n);
    inst_req = 1'b0;

    // reset in D_DATA, then a stray data_ok
    dw = 5;
    push_bus(32'h80000060, 1'b0, 4'h0, 32'h0);
    @(posedge clk); #1;
    data_req = 1'b1; data_addr = 32'h80000060;
    wait_neg(0, "rst_addr_ok");
    @(posedge clk); #2;
    rst = 1'b0; data_req = 1'b0;
    #1;
    chk("mid_rst_mem_req", 32'(mem_req), 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_inst_rdata", inst_rdata, 0);
    chk("mid_rst_data_rdata", data_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; dw = 0;
    @(negedge clk) late_ok = 1'b1;
    @(negedge clk) late_ok = 1'b0;
    chk("late_ok_seen", 32'(mem_data_ok), 1);
    repeat (3) begin
      @(negedge clk);
      chk("late_no_done", 32'(data_done), 0);
      chk("late_no_req", 32'(mem_req), 0);
      chk("late_rdata", data_rdata, 0);
    end

    chk("bus_queue_empty", 32'(exp_bus.size()), 0);
    chk("done_queue_empty", 32'(exp_done.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
